strassen_mm_seq: RTL and testbench

Parametrised, handshaked Strassen matrix multiplier for one N×N tile per transaction, with optional accumulation into the previous result.
- One 2×2 Strassen level splits each operand into Q×Q quadrants (Q = N/2).
- The seven quadrant products M0..M6 are computed serially on a single shared Q×Q MAC array.
- Sits between the SNN weight/activation tile buffers and the accumulator fabric.
- Accumulate mode lets a host tile larger matrices as a sum of N×N tile products.

---
 rtl/smm_pkg.sv | 45 ++++
 rtl/smm_quad_mac.sv | 30 +++
 rtl/strassen_mm_seq.sv | 209 ++++++++++++++++++++
 tb/tb_strassen_mm_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/smm_pkg.sv
// Shared definitions for the Strassen tile multiplier: FSM states, element
// indexing and element-wise quadrant add/subtract on flat packed vectors.
package smm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_MUL,
        ST_COMB,
        ST_OUT
    } state_t;

    // Upper bound on Q*Q*DATAWIDTH; quadrant helpers work on this fixed width.
    localparam int unsigned QVEC_MAX = 4096;
    typedef logic [QVEC_MAX-1:0] qvec_t;

    function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c,
                                             input int unsigned n);
        return r * n + c;
    endfunction

    function automatic qvec_t mat_op(input qvec_t a, input qvec_t b, input int unsigned dw,
                                     input int unsigned q, input logic sub);
        qvec_t mask, ea, eb, res;
        mask = (qvec_t'(1) << dw) - qvec_t'(1);
        res  = '0;
        for (int unsigned i = 0; i < q * q; i++) begin
            ea  = (a >> (i * dw)) & mask;
            eb  = (b >> (i * dw)) & mask;
            res = res | (((sub ? (ea - eb) : (ea + eb)) & mask) << (i * dw));
        end
        return res;
    endfunction

    function automatic qvec_t mat_add(input qvec_t a, input qvec_t b, input int unsigned dw,
                                      input int unsigned q);
        return mat_op(a, b, dw, q, 1'b0);
    endfunction

    function automatic qvec_t mat_sub(input qvec_t a, input qvec_t b, input int unsigned dw,
                                      input int unsigned q);
        return mat_op(a, b, dw, q, 1'b1);
    endfunction

endpackage

// File: rtl/smm_quad_mac.sv
// Q x Q array of multiply-accumulate cells fed by a column and a row vector
// (outer-product step). clear with enable starts a fresh sum.
module smm_quad_mac #(
    parameter int DATAWIDTH = 32,
    parameter int Q         = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [Q*DATAWIDTH-1:0]     col,
    input  logic [Q*DATAWIDTH-1:0]     row,
    input  logic                       clear,
    input  logic                       en,
    output logic [Q*Q*DATAWIDTH-1:0]   sum
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
        end else if (en) begin
            for (int unsigned i = 0; i < Q; i++) begin
                for (int unsigned j = 0; j < Q; j++) begin
                    sum[(i*Q+j)*DATAWIDTH +: DATAWIDTH] <=
                        (clear ? '0 : sum[(i*Q+j)*DATAWIDTH +: DATAWIDTH]) +
                        col[i*DATAWIDTH +: DATAWIDTH] * row[j*DATAWIDTH +: DATAWIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/strassen_mm_seq.sv
// One-level Strassen N x N tile multiplier: seven quadrant products computed
// serially on a shared Q x Q MAC array, with optional accumulation into C_out.
module strassen_mm_seq
    import smm_pkg::*;
#(
    parameter  int DATAWIDTH = 32,
    parameter  int N         = 4,
    localparam int BUSWIDTH  = N * N * DATAWIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BUSWIDTH-1:0] A,
    input  logic [BUSWIDTH-1:0] B,
    input  logic                acc_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BUSWIDTH-1:0] C_out,
    output logic                busy
);

    localparam int Q     = N / 2;
    localparam int QW    = Q * Q * DATAWIDTH;
    localparam int KW    = (Q > 1) ? $clog2(Q) : 1;
    localparam int NPROD = 7;

    state_t                 state, state_nxt;
    logic [BUSWIDTH-1:0]    a_r, b_r;
    logic                   acc_r;
    logic [QW-1:0]          t_r [NPROD];
    logic [QW-1:0]          s_r [NPROD];
    logic [QW-1:0]          m_r [NPROD];
    logic [2:0]             p_cnt;
    logic [KW-1:0]          k_cnt;
    logic                   accept, k_last, mul_last, mac_en, mac_clr;
    logic [Q*DATAWIDTH-1:0] mac_col, mac_row;
    logic [QW-1:0]          mac_sum;
    logic [QW-1:0]          a_q [4];
    logic [QW-1:0]          b_q [4];
    logic [QW-1:0]          c_q [4];
    logic [QW-1:0]          t_nxt [NPROD];
    logic [QW-1:0]          s_nxt [NPROD];
    logic [BUSWIDTH-1:0]    c_nxt;

    function automatic logic [QW-1:0] qadd(input logic [QW-1:0] x, input logic [QW-1:0] y);
        return QW'(mat_add(qvec_t'(x), qvec_t'(y), DATAWIDTH, Q));
    endfunction

    function automatic logic [QW-1:0] qsub(input logic [QW-1:0] x, input logic [QW-1:0] y);
        return QW'(mat_sub(qvec_t'(x), qvec_t'(y), DATAWIDTH, Q));
    endfunction

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_PREP;
            ST_PREP: state_nxt = ST_MUL;
            ST_MUL:  if (mul_last) state_nxt = ST_COMB;
            ST_COMB: state_nxt = ST_OUT;
            ST_OUT:  if (out_ready) state_nxt = in_valid ? ST_PREP : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs and datapath controls
    always_comb begin
        in_ready = rst && (state == ST_IDLE || (state == ST_OUT && out_ready));
        accept   = in_valid && in_ready;
        busy     = (state == ST_PREP) || (state == ST_MUL) || (state == ST_COMB);
        k_last   = (k_cnt == KW'(Q - 1));
        mul_last = (state == ST_MUL) && (p_cnt == 3'd6) && k_last;
        mac_en   = (state == ST_MUL);
        mac_clr  = (k_cnt == '0);
    end

    // Quadrant split; index 0..3 = X00, X01, X10, X11
    always_comb begin
        for (int unsigned qd = 0; qd < 4; qd++) begin
            a_q[qd] = '0;
            b_q[qd] = '0;
        end
        for (int unsigned r = 0; r < Q; r++) begin
            for (int unsigned c = 0; c < Q; c++) begin
                for (int unsigned qd = 0; qd < 4; qd++) begin
                    a_q[qd][elem_idx(r, c, Q)*DATAWIDTH +: DATAWIDTH] =
                        a_r[elem_idx(r + (qd / 2) * Q, c + (qd % 2) * Q, N)*DATAWIDTH +: DATAWIDTH];
                    b_q[qd][elem_idx(r, c, Q)*DATAWIDTH +: DATAWIDTH] =
                        b_r[elem_idx(r + (qd / 2) * Q, c + (qd % 2) * Q, N)*DATAWIDTH +: DATAWIDTH];
                end
            end
        end
    end

    always_comb begin
        t_nxt[0] = qadd(a_q[0], a_q[3]);
        t_nxt[1] = qadd(a_q[2], a_q[3]);
        t_nxt[2] = a_q[0];
        t_nxt[3] = a_q[3];
        t_nxt[4] = qadd(a_q[0], a_q[1]);
        t_nxt[5] = qsub(a_q[2], a_q[0]);
        t_nxt[6] = qsub(a_q[1], a_q[3]);
        s_nxt[0] = qadd(b_q[0], b_q[3]);
        s_nxt[1] = b_q[0];
        s_nxt[2] = qsub(b_q[1], b_q[3]);
        s_nxt[3] = qsub(b_q[2], b_q[0]);
        s_nxt[4] = b_q[3];
        s_nxt[5] = qadd(b_q[0], b_q[1]);
        s_nxt[6] = qadd(b_q[2], b_q[3]);
    end

    always_comb begin
        mac_col = '0;
        mac_row = '0;
        for (int unsigned i = 0; i < Q; i++) begin
            mac_col[i*DATAWIDTH +: DATAWIDTH] =
                t_r[p_cnt][elem_idx(i, int'(k_cnt), Q)*DATAWIDTH +: DATAWIDTH];
            mac_row[i*DATAWIDTH +: DATAWIDTH] =
                s_r[p_cnt][elem_idx(int'(k_cnt), i, Q)*DATAWIDTH +: DATAWIDTH];
        end
    end

    smm_quad_mac #(
        .DATAWIDTH (DATAWIDTH),
        .Q         (Q)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .col   (mac_col),
        .row   (mac_row),
        .clear (mac_clr),
        .en    (mac_en),
        .sum   (mac_sum)
    );

    // M6 is still held in the MAC array during COMB, so it is read from there.
    always_comb begin
        c_q[0] = qadd(qsub(qadd(m_r[0], m_r[3]), m_r[4]), mac_sum);
        c_q[1] = qadd(m_r[2], m_r[4]);
        c_q[2] = qadd(m_r[1], m_r[3]);
        c_q[3] = qadd(qadd(qsub(m_r[0], m_r[1]), m_r[2]), m_r[5]);
        c_nxt  = '0;
        for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
                c_nxt[elem_idx(r, c, N)*DATAWIDTH +: DATAWIDTH] =
                    c_q[(r / Q) * 2 + c / Q][elem_idx(r % Q, c % Q, Q)*DATAWIDTH +: DATAWIDTH] +
                    (acc_r ? C_out[elem_idx(r, c, N)*DATAWIDTH +: DATAWIDTH] : '0);
            end
        end
    end

    // Each finished product is banked one cycle late, when the array restarts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r       <= '0;
            b_r       <= '0;
            acc_r     <= 1'b0;
            p_cnt     <= '0;
            k_cnt     <= '0;
            C_out     <= '0;
            out_valid <= 1'b0;
            for (int unsigned p = 0; p < NPROD; p++) begin
                t_r[p] <= '0;
                s_r[p] <= '0;
                m_r[p] <= '0;
            end
        end else begin
            if (accept) begin
                a_r   <= A;
                b_r   <= B;
                acc_r <= acc_en;
            end
            if (state == ST_OUT && out_ready) out_valid <= 1'b0;
            case (state)
                ST_PREP: begin
                    for (int unsigned p = 0; p < NPROD; p++) begin
                        t_r[p] <= t_nxt[p];
                        s_r[p] <= s_nxt[p];
                    end
                    p_cnt <= '0;
                    k_cnt <= '0;
                end
                ST_MUL: begin
                    if (k_cnt == '0 && p_cnt != '0) m_r[p_cnt - 3'd1] <= mac_sum;
                    if (k_last) begin
                        k_cnt <= '0;
                        p_cnt <= mul_last ? '0 : p_cnt + 3'd1;
                    end else begin
                        k_cnt <= k_cnt + 1'b1;
                    end
                end
                ST_COMB: begin
                    m_r[NPROD-1] <= mac_sum;
                    C_out        <= c_nxt;
                    out_valid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_strassen_mm_seq.sv
// Directed and randomized checks of strassen_mm_seq against a plain
// triple-loop matrix product model with a tracked accumulator tile.
module tb_strassen_mm_seq;

    localparam int DW  = 32;
    localparam int N   = 4;
    localparam int BW  = N * N * DW;
    localparam int LAT = 7 * (N / 2) + 2;

    typedef logic [BW-1:0] mat_t;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    logic    in_valid = 1'b0;
    logic    in_ready;
    mat_t    A = '0;
    mat_t    B = '0;
    logic    acc_en = 1'b0;
    logic    out_valid;
    logic    out_ready = 1'b0;
    mat_t    C_out;
    logic    busy;

    int      n_checks = 0;
    int      n_pass   = 0;
    mat_t    c_model  = '0;

    strassen_mm_seq #(
        .DATAWIDTH (DW),
        .N         (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .acc_en    (acc_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C_out     (C_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic mat_t mat_mul(input mat_t a, input mat_t b);
        mat_t r;
        logic [DW-1:0] s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++)
                    s = s + a[(i*N+k)*DW +: DW] * b[(k*N+j)*DW +: DW];
                r[(i*N+j)*DW +: DW] = s;
            end
        end
        return r;
    endfunction

    function automatic mat_t mat_plus(input mat_t a, input mat_t b);
        mat_t r;
        for (int i = 0; i < N * N; i++) r[i*DW +: DW] = a[i*DW +: DW] + b[i*DW +: DW];
        return r;
    endfunction

    function automatic mat_t ident(input logic [DW-1:0] k);
        mat_t r;
        r = '0;
        for (int i = 0; i < N; i++) r[(i*N+i)*DW +: DW] = k;
        return r;
    endfunction

    function automatic mat_t fill(input logic [DW-1:0] v);
        mat_t r;
        for (int i = 0; i < N * N; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    function automatic mat_t rand_mat();
        mat_t r;
        for (int i = 0; i < N * N; i++) r[i*DW +: DW] = $urandom;
        return r;
    endfunction

    task automatic check(input string tag, input mat_t obs, input mat_t exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic start_txn(input mat_t a, input mat_t b, input logic acc);
        @(negedge clk);
        A = a; B = b; acc_en = acc; in_valid = 1'b1;
        #1 check("in_ready_idle", BW'(in_ready), BW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0; A = '0; B = '0; acc_en = 1'b0;
        check("busy_after_accept", BW'(busy), BW'(1));
        c_model = acc ? mat_plus(c_model, mat_mul(a, b)) : mat_mul(a, b);
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_latency"}, BW'(n), BW'(LAT));
        check(tag, C_out, c_model);
    endtask

    task automatic deliver();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("out_valid_drop", BW'(out_valid), BW'(0));
        check("in_ready_after_out", BW'(in_ready), BW'(1));
    endtask

    initial begin
        mat_t seq, held;
        int rises;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", BW'(out_valid), BW'(0));
        check("rst_c_out", C_out, '0);
        check("rst_in_ready", BW'(in_ready), BW'(0));
        check("rst_busy", BW'(busy), BW'(0));
        rst = 1'b1;
        #1 check("in_ready_release", BW'(in_ready), BW'(1));

        // Identity times 1..16
        for (int i = 0; i < N * N; i++) seq[i*DW +: DW] = DW'(i + 1);
        start_txn(ident(1), seq, 1'b0);
        wait_result("ident_x_seq");
        check("ident_x_seq_const", C_out, seq);
        deliver();

        // Wrap-around
        start_txn(fill(32'h7FFF_FFFF), fill(32'h0000_0002), 1'b0);
        wait_result("wrap");
        check("wrap_const", C_out, fill(32'hFFFF_FFF8));
        deliver();

        // Accumulate I, 2I, I
        start_txn(ident(1), ident(1), 1'b0);
        wait_result("acc_step0");
        deliver();
        start_txn(ident(1), ident(1), 1'b1);
        wait_result("acc_step1");
        check("acc_step1_const", C_out, ident(2));
        deliver();
        start_txn(ident(1), ident(1), 1'b0);
        wait_result("acc_step2");
        check("acc_step2_const", C_out, ident(1));
        deliver();

        // Random operands, random accumulate
        for (int t = 0; t < 6; t++) begin
            start_txn(rand_mat(), rand_mat(), 1'($urandom_range(0, 1)));
            wait_result("random");
            deliver();
        end

        // Backpressure then back-to-back accept
        start_txn(ident(1), ident(1), 1'b0);
        wait_result("bp_first");
        held = C_out;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_c_out_stable", C_out, ident(1));
            check("bp_in_ready", BW'(in_ready), BW'(0));
            check("bp_out_valid", BW'(out_valid), BW'(1));
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; A = ident(2); B = ident(1); acc_en = 1'b1;
        #1 check("b2b_in_ready", BW'(in_ready), BW'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b0; in_valid = 1'b0; acc_en = 1'b0;
        check("b2b_out_valid_low", BW'(out_valid), BW'(0));
        check("b2b_busy", BW'(busy), BW'(1));
        c_model = mat_plus(held, mat_mul(ident(2), ident(1)));
        wait_result("b2b_result");
        check("b2b_const", C_out, ident(3));
        deliver();

        // Reset in the middle of MUL
        start_txn(rand_mat(), rand_mat(), 1'b0);
        repeat (8) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_out_valid", BW'(out_valid), BW'(0));
        check("midrst_c_out", C_out, '0);
        check("midrst_busy", BW'(busy), BW'(0));
        check("midrst_in_ready", BW'(in_ready), BW'(0));
        c_model = '0;
        @(negedge clk);
        rst = 1'b1;
        rises = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (out_valid === 1'b1) rises++;
        end
        check("midrst_no_result", BW'(rises), BW'(0));
        start_txn(ident(1), ident(1), 1'b1);
        wait_result("post_rst_acc");
        check("post_rst_const", C_out, ident(1));
        deliver();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
